// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 mux/arbiter.
package mux_pkg;

    localparam int MODE_DIRECT = 0;
    localparam int MODE_RR     = 1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_arb_nto1_rr_arbiter.sv
// Round-robin grant search: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    localparam logic [SELW:0] NUM = (SELW+1)'(N);

    logic [SELW:0] cand;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so one subtraction brings cand back into range
            cand = {1'b0, ptr} + (SELW+1)'(k);
            if (cand >= NUM)
                cand = cand - NUM;
            if (!gnt_any && req[cand[SELW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[SELW-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 channel mux with a single registered output stage; direct select or round-robin.
module mux_arb_nto1
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    parameter  int MODE  = MODE_DIRECT,
    localparam int SELW  = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] din,
    input  logic [N-1:0]       din_valid,
    output logic [N-1:0]       din_ready,
    output logic [WIDTH-1:0]   dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [SELW-1:0]    dout_chan
);

    localparam logic [SELW:0] NUM = (SELW+1)'(N);

    logic              load;
    logic              xfer;
    logic [SELW-1:0]   gnt_idx;
    logic              gnt_any;
    logic [SELW-1:0]   ptr;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_vld;

    assign load = !dout_valid || dout_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic unused_sel;
            assign unused_sel = ^sel;

            rr_arbiter #(.N(N)) u_arb (
                .req     (din_valid),
                .ptr     (ptr),
                .gnt_idx (gnt_idx),
                .gnt_any (gnt_any)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    ptr <= '0;
                else if (xfer)
                    ptr <= (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
            end
        end else begin : g_direct
            // Out-of-range select (non power-of-two N) yields no grant at all
            assign gnt_idx = sel;
            assign gnt_any = ({1'b0, sel} < NUM);
            assign ptr     = '0;
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        sel_vld  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt_any && gnt_idx == SELW'(i)) begin
                sel_data = din[i*WIDTH +: WIDTH];
                sel_vld  = din_valid[i];
            end
        end
    end

    always_comb begin
        din_ready = '0;
        for (int i = 0; i < N; i++)
            din_ready[i] = !rst && gnt_any && load && (gnt_idx == SELW'(i));
    end

    assign xfer = gnt_any && load && sel_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_chan  <= '0;
        end else if (load) begin
            dout_valid <= xfer;
            if (xfer) begin
                dout      <= sel_data;
                dout_chan <= gnt_idx;
            end
        end
    end

endmodule
